// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and limits for the parametrised serial pattern
//               detector (fill-state encoding, legal pattern width range).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

   // Fill FSM: how much of the history window holds valid bits.
   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_FILLING = 2'd1,
      FILL_PRIMED  = 2'd2
   } fill_state_e;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

endpackage : seq_det_pkg

`default_nettype wire

// File: rtl/seq_match_counter.sv
// ============================================================================
// Module      : seq_match_counter
// Description : Saturating match counter with synchronous clear. Clear wins
//               over a simultaneous increment. Only compiled when the
//               MATCH_COUNT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MATCH_COUNT_EN
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             sat_w;

   assign sat_w = &cnt_q;

   // Count matches, holding at all-ones; a clear discards a coincident match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !sat_w) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = sat_w;

endmodule : seq_match_counter
`endif

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module      : seq_detector_param
// Description : Parametrised serial pattern detector. Compares the newest
//               PAT_W accepted bits against a runtime-loadable pattern and
//               emits a registered one-cycle match pulse. Supports
//               overlapping / non-overlapping detection and a din qualifier.
//               Optional saturating match counter enabled by the
//               MATCH_COUNT_EN macro; without it match_cnt_o and cnt_sat_o
//               are tied low and cnt_clr_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] DEF_PAT = 3'b101,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid_i,
   input  logic             din_i,
   input  logic             overlap_i,
   input  logic             pat_load_i,
   input  logic [PAT_W-1:0] pat_in_i,
   input  logic             cnt_clr_i,
   output logic             match_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic             cnt_sat_o
);

   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   generate
      if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
         $error("seq_detector_param: PAT_W=%0d outside legal range 2..16", PAT_W);
      end
   endgenerate

   fill_state_e       state_q;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_d;
   logic [PAT_W-2:0]  hist_q;
   logic [PAT_W-1:0]  pattern_q;
   logic              match_q;
   logic              match_d;
   logic [PAT_W-1:0]  cand;
   logic              hit;

   // The candidate window is the stored history plus the bit on din this cycle.
   assign cand    = {hist_q, din_i};
   assign hit     = (state_q == FILL_PRIMED) && (cand == pattern_q);
   assign fill_d  = fill_q + FILL_W'(1);
   // A match is only registered for a bit that is actually accepted.
   assign match_d = !pat_load_i && din_valid_i && hit;

   // Fill FSM, history shift register, pattern register and match pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FILL_EMPTY;
         fill_q    <= '0;
         hist_q    <= '0;
         pattern_q <= DEF_PAT;
         match_q   <= 1'b0;
      end else begin
         match_q <= match_d;
         if (pat_load_i) begin
            pattern_q <= pat_in_i;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= FILL_EMPTY;
         end else if (din_valid_i) begin
            hist_q <= cand[PAT_W-2:0];
            if (hit && !overlap_i) begin
               fill_q  <= '0;
               state_q <= FILL_EMPTY;
            end else if (state_q != FILL_PRIMED) begin
               fill_q  <= fill_d;
               state_q <= (fill_d == FILL_MAX) ? FILL_PRIMED : FILL_FILLING;
            end
         end
      end
   end

   assign match_o = match_q;

`ifdef MATCH_COUNT_EN
   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_match_counter (
      .clk   (clk),
      .reset (reset),
      .inc_i (match_d),
      .clr_i (cnt_clr_i),
      .cnt_o (match_cnt_o),
      .sat_o (cnt_sat_o)
   );
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign match_cnt_o    = '0;
   assign cnt_sat_o      = 1'b0;
`endif

endmodule : seq_detector_param

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param: directed vector
//               table, hand-written corner sequences and random stimulus
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

   localparam int         PAT_W   = 3;
   localparam int         CNT_W   = 2;
   localparam logic [2:0] DEF_PAT = 3'b101;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             din_valid = 1'b0;
   logic             din = 1'b0;
   logic             overlap = 1'b1;
   logic             pat_load = 1'b0;
   logic [PAT_W-1:0] pat_in = '0;
   logic             cnt_clr = 1'b0;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   int errors = 0;
   int checks = 0;

   // Reference model state: accepted bits since the last flush, current pattern, count.
   bit         mq[$];
   logic [2:0] m_pat = DEF_PAT;
   int         m_cnt = 0;

   seq_detector_param #(
      .PAT_W   (PAT_W),
      .DEF_PAT (DEF_PAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .din_valid_i (din_valid),
      .din_i       (din),
      .overlap_i   (overlap),
      .pat_load_i  (pat_load),
      .pat_in_i    (pat_in),
      .cnt_clr_i   (cnt_clr),
      .match_o     (match),
      .match_cnt_o (match_cnt),
      .cnt_sat_o   (cnt_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef MATCH_COUNT_EN
      return 32'(m_cnt);
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_sat();
`ifdef MATCH_COUNT_EN
      return (m_cnt == CNT_MAX) ? 32'd1 : 32'd0;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pat = DEF_PAT;
      m_cnt = 0;
   endtask

   // Behavioural rule: a match is the newest PAT_W accepted bits equal to the pattern.
   task automatic model_step(input bit v, input bit d, input bit o, input bit l,
                             input logic [2:0] p, input bit c, output bit em);
      em = 1'b0;
      if (l) begin
         m_pat = p;
         mq.delete();
      end else if (v) begin
         mq.push_back(d);
         if (mq.size() >= PAT_W) begin
            int val;
            val = 0;
            for (int i = 0; i < PAT_W; i++)
               val = (val << 1) | int'(mq[mq.size() - PAT_W + i]);
            em = (val == int'(m_pat));
         end
         if (em && !o) mq.delete();
         while (mq.size() > PAT_W) void'(mq.pop_front());
      end
      if (c) m_cnt = 0;
      else if (em && m_cnt < CNT_MAX) m_cnt++;
   endtask

   // One clock of stimulus; outputs compared against the model just after the edge.
   task automatic apply(input string tag, input bit v, input bit d, input bit o, input bit l,
                        input logic [2:0] p, input bit c, output bit em);
      @(negedge clk);
      din_valid = v; din = d; overlap = o; pat_load = l; pat_in = p; cnt_clr = c;
      model_step(v, d, o, l, p, c, em);
      @(posedge clk);
      #1;
      check({tag, "_match"}, 32'(match), 32'(em));
      check({tag, "_cnt"}, 32'(match_cnt), exp_cnt());
      check({tag, "_sat"}, 32'(cnt_sat), exp_sat());
   endtask

   // Asynchronous reset pulse that does not straddle a rising edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      din_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
      #1;
      check({tag, "_rst_match"}, 32'(match), 32'd0);
      check({tag, "_rst_cnt"}, 32'(match_cnt), 32'd0);
      check({tag, "_rst_sat"}, 32'(cnt_sat), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      bit         rst;
      bit         v;
      bit         d;
      bit         o;
      bit         l;
      logic [2:0] p;
      bit         c;
      bit         e;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit v, bit d, bit o, bit l, logic [2:0] p, bit e);
      vec_t r;
      r.rst = rst; r.v = v; r.d = d; r.o = o; r.l = l; r.p = p; r.c = 1'b0; r.e = e;
      return r;
   endfunction

   initial begin
      bit em;

      // Overlapping: 1,0,1,0,1 matches after bits 3 and 5.
      tbl.push_back(mk(1, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 1));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 1));
      // Non-overlapping: only the first match.
      tbl.push_back(mk(1, 1, 1, 0, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 3'b000, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0));
      // Load 110 with a din=1 offered alongside: that bit must be discarded.
      tbl.push_back(mk(1, 1, 1, 1, 1, 3'b110, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0));
      // Load 110, then 1,1,0,1,1,0 matches after bits 3 and 6.
      tbl.push_back(mk(1, 1, 1, 1, 1, 3'b110, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 1));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 1));
      // Qualifier gaps: 1, three invalid cycles, 0, 1.
      tbl.push_back(mk(1, 1, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 1));

      do_reset("init");

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
         apply($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].l,
               tbl[i].p, tbl[i].c, em);
         check($sformatf("tbl%0d_vec", i), 32'(match), 32'(tbl[i].e));
      end

      // Counter saturation and clear-wins-over-match.
      do_reset("sat");
      for (int i = 0; i < 9; i++)
         apply("sat_stream", 1, (i % 2 == 0), 1, 0, 3'b000, 0, em);
`ifdef MATCH_COUNT_EN
      check("sat_cnt_full", 32'(match_cnt), 32'd3);
      check("sat_flag_set", 32'(cnt_sat), 32'd1);
`else
      check("sat_cnt_full", 32'(match_cnt), 32'd0);
      check("sat_flag_set", 32'(cnt_sat), 32'd0);
`endif
      apply("clr_a", 1, 0, 1, 0, 3'b000, 0, em);
      apply("clr_b", 1, 1, 1, 0, 3'b000, 1, em);
      check("clr_b_hit", 32'(match), 32'd1);
      apply("clr_c", 0, 0, 1, 0, 3'b000, 1, em);
      check("clr_cnt_zero", 32'(match_cnt), 32'd0);
      check("clr_sat_zero", 32'(cnt_sat), 32'd0);

      // Reset mid-stream discards partial history.
      do_reset("mid");
      apply("mid_a", 1, 1, 1, 0, 3'b000, 0, em);
      apply("mid_b", 1, 0, 1, 0, 3'b000, 0, em);
      do_reset("mid_rst");
      apply("mid_c", 1, 1, 1, 0, 3'b000, 0, em);
      check("mid_c_nomatch", 32'(match), 32'd0);
      apply("mid_d", 1, 0, 1, 0, 3'b000, 0, em);
      apply("mid_e", 1, 1, 1, 0, 3'b000, 0, em);
      check("mid_e_match", 32'(match), 32'd1);

      // Random traffic against the reference model.
      do_reset("rnd");
      for (int i = 0; i < 600; i++) begin
         bit         v, d, o, l, c;
         logic [2:0] p;
         v = ($urandom_range(0, 3) != 0);
         d = 1'($urandom);
         o = ($urandom_range(0, 4) != 0);
         l = ($urandom_range(0, 39) == 0);
         p = 3'($urandom);
         c = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
         apply("rnd", v, d, o, l, p, c, em);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seq_detector_param

`default_nettype wire
